// File: rtl/mem_access_unit.sv
// Load/store sequencer: splits one RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW request into
// little-endian byte accesses on a byte-wide RAM with a one-cycle registered read.
module mem_access_unit #(
  parameter logic check_alignment = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] mem_address,
  output logic [7:0]  mem_write_data,
  output logic        mem_write_enable,
  input  logic [7:0]  mem_read_data,
  input  logic        mem_illegal_address
);

  // Handshake: a request is taken when start=1 and busy=0; the result (load_data,
  // error) is valid while done=1, which is a single-cycle pulse.
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] base, sdata, asm_q, asm_next;
  logic [2:0]  f3, n_q, k_q, k_inc, req_n;
  logic        req_bad, issuing, last_write;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    byte_sel = w[7:0];
      2'd1:    byte_sel = w[15:8];
      2'd2:    byte_sel = w[23:16];
      default: byte_sel = w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] a, input logic [2:0] f);
    case (f)
      3'b000:  extend = {{24{a[7]}}, a[7:0]};
      3'b001:  extend = {{16{a[15]}}, a[15:0]};
      3'b100:  extend = {24'h0, a[7:0]};
      3'b101:  extend = {16'h0, a[15:0]};
      default: extend = a;
    endcase
  endfunction

  always_comb begin
    req_n = 3'd1;
    if (funct3[1:0] == 2'b01)      req_n = 3'd2;
    else if (funct3[1:0] == 2'b10) req_n = 3'd4;
    req_bad = (funct3[1:0] == 2'b11) || (funct3[2:1] == 2'b11) || (is_store && funct3[2]);
    if (check_alignment)
      req_bad = req_bad || (funct3[1:0] == 2'b01 && address[0])
                        || (funct3[1:0] == 2'b10 && address[1:0] != 2'b00);
  end

  assign k_inc      = k_q + 3'd1;
  assign issuing    = (state == READ) && (k_q < n_q);
  assign last_write = (k_inc == n_q);

  // In READ cycle k the byte issued in cycle k-1 is on mem_read_data.
  always_comb begin
    asm_next = asm_q;
    case (k_q)
      3'd1:    asm_next[7:0]   = mem_read_data;
      3'd2:    asm_next[15:8]  = mem_read_data;
      3'd3:    asm_next[23:16] = mem_read_data;
      3'd4:    asm_next[31:24] = mem_read_data;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next       = state;
    mem_write_enable = 1'b0;
    case (state)
      IDLE:  if (start) state_next = req_bad ? DONE : (is_store ? WRITE : READ);
      WRITE: begin
        mem_write_enable = !mem_illegal_address;
        if (mem_illegal_address || last_write) state_next = DONE;
      end
      READ:  if ((issuing && mem_illegal_address) || k_q == n_q) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base           <= '0;
      sdata          <= '0;
      asm_q          <= '0;
      f3             <= '0;
      n_q            <= '0;
      k_q            <= '0;
      load_data      <= '0;
      error          <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          base  <= address;
          f3    <= funct3;
          sdata <= store_data;
          n_q   <= req_n;
          k_q   <= '0;
          if (req_bad) error <= 1'b1;
          else begin
            mem_address <= address;
            if (is_store) mem_write_data <= store_data[7:0];
          end
        end
        WRITE: begin
          if (mem_illegal_address) error <= 1'b1;
          else if (last_write)     error <= 1'b0;
          else begin
            k_q            <= k_inc;
            mem_address    <= base + {29'b0, k_inc};
            mem_write_data <= byte_sel(sdata, k_inc[1:0]);
          end
        end
        READ: begin
          if (issuing && mem_illegal_address) error <= 1'b1;
          else begin
            asm_q <= asm_next;
            k_q   <= k_inc;
            if (k_inc < n_q) mem_address <= base + {29'b0, k_inc};
            if (k_q == n_q) begin
              load_data <= extend(asm_next, f3);
              error     <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
